md_unit: RTL and testbench

//  E-stage multiply/divide unit with HI/LO registers. Executes mult/multu/div/divu

---
 rtl/md_unit_if.sv | 34 +++
 rtl/md_unit.sv | 115 +++++++++++
 tb/tb_md_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Operand/result bundle between the E-stage and the multiply/divide unit.
// The md_cancel signal exists only when MD_CANCEL_EN is defined.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        isMD_D;
`ifdef MD_CANCEL_EN
    logic        md_cancel;
`endif
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    // start is a one-cycle pulse, accepted only while busy is low.
    // md_stall tells the D stage to hold any MD-class instruction.
    modport master (
        output start, md_op, A, B, isMD_D,
`ifdef MD_CANCEL_EN
        output md_cancel,
`endif
        input  busy, md_stall, HI, LO
    );

    modport slave (
        input  start, md_op, A, B, isMD_D,
`ifdef MD_CANCEL_EN
        input  md_cancel,
`endif
        output busy, md_stall, HI, LO
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional feature MD_CANCEL_EN: a flushed E-stage instruction suppresses start.
module md_unit #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus,
    output logic       dbg_run_o
);
    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W = $clog2(MAX_LAT + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q, lo_q;
    logic [31:0]      hi_n_q, lo_n_q;
    logic             wr_n_q;

    logic             start_eff;
    logic [63:0]      mul_a, mul_b, prod;
    logic             is_mul, sdiv, a_neg, b_neg, div_zero;
    logic [31:0]      a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
    logic [31:0]      res_hi_d, res_lo_d;
    logic             res_wr_d;

`ifdef MD_CANCEL_EN
    assign start_eff = bus.start & ~bus.md_cancel;
`else
    assign start_eff = bus.start;
`endif

    always_comb begin
        is_mul = (bus.md_op == 3'd0) || (bus.md_op == 3'd1);
        // One 64-bit multiplier; mult sign-extends, multu zero-extends.
        mul_a  = {((bus.md_op == 3'd0) && bus.A[31]) ? 32'hFFFF_FFFF : 32'h0, bus.A};
        mul_b  = {((bus.md_op == 3'd0) && bus.B[31]) ? 32'hFFFF_FFFF : 32'h0, bus.B};
        prod   = mul_a * mul_b;

        // Signed divide on magnitudes keeps 0x80000000 / -1 well defined.
        sdiv     = (bus.md_op == 3'd2);
        a_neg    = sdiv & bus.A[31];
        b_neg    = sdiv & bus.B[31];
        a_mag    = a_neg ? (~bus.A + 32'd1) : bus.A;
        b_mag    = b_neg ? (~bus.B + 32'd1) : bus.B;
        div_zero = (bus.B == 32'd0);
        b_safe   = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        quo      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem      = a_neg ? (~r_mag + 32'd1) : r_mag;

        res_hi_d = is_mul ? prod[63:32] : rem;
        res_lo_d = is_mul ? prod[31:0]  : quo;
        res_wr_d = is_mul | ~div_zero;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_n_q  <= '0;
            lo_n_q  <= '0;
            wr_n_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_eff) begin
                        case (bus.md_op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                hi_n_q  <= res_hi_d;
                                lo_n_q  <= res_lo_d;
                                wr_n_q  <= res_wr_d;
                                cnt_q   <= is_mul ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
                                busy_q  <= 1'b1;
                                state_q <= RUN;
                            end
                            3'd4:    hi_q <= bus.A;
                            3'd5:    lo_q <= bus.A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Starts arriving here are protocol violations and are dropped.
                    if (cnt_q == CNT_W'(1)) begin
                        if (wr_n_q) begin
                            hi_q <= hi_n_q;
                            lo_q <= lo_n_q;
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign bus.md_stall = bus.isMD_D & (start_eff | busy_q);
    assign dbg_run_o    = (state_q == RUN);
endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases with literal results, then random traffic
// compared every cycle against a behavioural HI/LO model.
module tb_md_unit;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk = 1'b0;
  logic reset;
  logic dbg_run;
  md_unit_if bus();

  md_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_run_o(dbg_run)
  );

  // clock/reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  // model state: architectural HI/LO, busy cycles left, pending write-backs {wr,hi,lo}
  logic [31:0] m_hi, m_lo;
  int          m_left;
  logic [64:0] exp_q[$];
  logic [64:0] m_res;
  logic        m_se;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic start_eff_now();
`ifdef MD_CANCEL_EN
    return bus.start & ~bus.md_cancel;
`else
    return bus.start;
`endif
  endfunction

  function automatic logic [64:0] model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'd0: begin q = sa * sb; return {1'b1, q[63:0]}; end
      3'd1: begin p = ua * ub; return {1'b1, p}; end
      3'd2: begin
        if (b == 32'd0) return 65'd0;
        q = sa / sb;
        r = sa % sb;
        return {1'b1, r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return 65'd0;
        return {1'b1, a % b, a / b};
      end
      default: return 65'd0;
    endcase
  endfunction

  // behavioural model, advanced on each rising edge
  always @(posedge clk) begin
    m_se = start_eff_now();
    if (reset !== 1'b1) begin
      m_hi = '0;
      m_lo = '0;
      m_left = 0;
      exp_q.delete();
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && exp_q.size() > 0) begin
        m_res = exp_q.pop_front();
        if (m_res[64]) begin
          m_hi = m_res[63:32];
          m_lo = m_res[31:0];
        end
      end
    end else if (m_se) begin
      case (bus.md_op)
        3'd0, 3'd1: begin exp_q.push_back(model_result(bus.md_op, bus.A, bus.B)); m_left = MULT_LAT; end
        3'd2, 3'd3: begin exp_q.push_back(model_result(bus.md_op, bus.A, bus.B)); m_left = DIV_LAT; end
        3'd4: m_hi = bus.A;
        3'd5: m_lo = bus.A;
        default: ;
      endcase
    end
  end

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, bus.busy}, {31'b0, m_left > 0});
      chk("dbg_run", {31'b0, dbg_run}, {31'b0, m_left > 0});
      chk("HI", bus.HI, m_hi);
      chk("LO", bus.LO, m_lo);
      chk("md_stall", {31'b0, bus.md_stall}, {31'b0, bus.isMD_D & (start_eff_now() | (m_left > 0))});
    end
  end

  // driver tasks
  task automatic set_cancel(input logic c);
`ifdef MD_CANCEL_EN
    bus.md_cancel = c;
`else
    if (c) begin end
`endif
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic cancel);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.md_op = op;
    bus.A = a;
    bus.B = b;
    set_cancel(cancel);
    @(posedge clk); #1;
    bus.start = 1'b0;
    set_cancel(1'b0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    repeat (20) begin
      if (bus.busy) n++;
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  int nb;

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.md_op = '0;
    bus.A = '0;
    bus.B = '0;
    bus.isMD_D = 1'b0;
    set_cancel(1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("reset_HI", bus.HI, 32'h0);
    chk("reset_LO", bus.LO, 32'h0);
    chk("reset_busy", {31'b0, bus.busy}, 32'h0);
    chk_en = 1'b1;

    issue(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    count_busy(nb);
    chk("mult_busy_cycles", 32'(nb), 32'd5);
    chk("mult_HI", bus.HI, 32'hFFFF_FFFF);
    chk("mult_LO", bus.LO, 32'hFFFF_FFFE);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    count_busy(nb);
    chk("multu_busy_cycles", 32'(nb), 32'd5);
    chk("multu_HI", bus.HI, 32'h0000_0001);
    chk("multu_LO", bus.LO, 32'hFFFF_FFFE);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    count_busy(nb);
    chk("div_busy_cycles", 32'(nb), 32'd10);
    chk("div_LO", bus.LO, 32'hFFFF_FFFD);
    chk("div_HI", bus.HI, 32'hFFFF_FFFF);

    issue(3'd3, 32'd7, 32'd0, 1'b0);
    count_busy(nb);
    chk("divu0_busy_cycles", 32'(nb), 32'd10);
    chk("divu0_LO", bus.LO, 32'hFFFF_FFFD);
    chk("divu0_HI", bus.HI, 32'hFFFF_FFFF);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    count_busy(nb);
    chk("div_ovf_LO", bus.LO, 32'h8000_0000);
    chk("div_ovf_HI", bus.HI, 32'h0);

    issue(3'd4, 32'h1234, 32'h0, 1'b0);
    chk("mthi_HI", bus.HI, 32'h1234);
    chk("mthi_busy", {31'b0, bus.busy}, 32'h0);

    bus.isMD_D = 1'b1;
    #1;
    chk("stall_idle", {31'b0, bus.md_stall}, 32'h0);
    bus.start = 1'b1;
    bus.md_op = 3'd5;
    bus.A = 32'h55;
    #1;
    chk("stall_start", {31'b0, bus.md_stall}, 32'h1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.isMD_D = 1'b0;
    chk("mtlo_LO", bus.LO, 32'h55);

    issue(3'd6, 32'hDEAD_BEEF, 32'h1, 1'b0);
    chk("op6_HI", bus.HI, 32'h1234);
    chk("op6_busy", {31'b0, bus.busy}, 32'h0);

    issue(3'd2, 32'd100, 32'd7, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_busy", {31'b0, bus.busy}, 32'h0);
    chk("abort_HI", bus.HI, 32'h0);
    chk("abort_LO", bus.LO, 32'h0);
    repeat (15) begin @(posedge clk); #1; end
    chk("abort_late_HI", bus.HI, 32'h0);
    chk("abort_late_LO", bus.LO, 32'h0);

    issue(3'd0, 32'd3, 32'd4, 1'b1);
    count_busy(nb);
`ifdef MD_CANCEL_EN
    chk("cancel_busy_cycles", 32'(nb), 32'd0);
    chk("cancel_LO", bus.LO, 32'h0);
`else
    chk("cancel_busy_cycles", 32'(nb), 32'd5);
    chk("cancel_LO", bus.LO, 32'd12);
`endif

    repeat (1500) begin
      @(posedge clk); #1;
      bus.start  = ($urandom_range(0, 2) == 0);
      bus.md_op  = 3'($urandom_range(0, 7));
      bus.A      = rand_operand();
      bus.B      = rand_operand();
      bus.isMD_D = 1'($urandom_range(0, 1));
      set_cancel($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.isMD_D = 1'b0;
    set_cancel(1'b0);
    repeat (DIV_LAT + 2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
